// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM states, owner IDs, response codes.
// No logic, no latency.
// No flow control.
`include "config.sv"

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Instruction fetches are always full-word reads.
    localparam logic [1:0] FETCH_SIZE = `SIZE_W;

endpackage

// File: rtl/config.sv
// Core-wide configuration macros: data-path width and bus access-size encodings.
// No logic; included by every file that needs these values.
// Guarded so that multiple inclusion is harmless.
`ifndef MEM_PORT_ARBITER_CONFIG_SV
`define MEM_PORT_ARBITER_CONFIG_SV

`define CPU_WIDTH 64

`define SIZE_B 2'b00
`define SIZE_H 2'b01
`define SIZE_W 2'b10
`define SIZE_D 2'b11

`endif

// File: rtl/mem_port_arbiter_arb_pick.sv
// Chooses which of fetch / LSU gets the bus; ARB_RR_EN selects round-robin, else mem over if.
// Latency: combinational grant; round-robin history updates one cycle after a completion.
// Backpressure: none here; the losing requester simply stays valid and is reconsidered later.
`include "config.sv"

module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_if,
    input  logic   req_mem,
    input  logic   done,
    input  owner_t done_owner,
    output logic   grant,
    output owner_t owner
);

`ifdef ARB_RR_EN
    owner_t last_owner;

    // Remember who completed most recently so a contended round favours the other side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_owner <= OWN_MEM;
        end else if (done) begin
            last_owner <= done_owner;
        end
    end

    // Lone requester wins at once; on contention the side that did not go last wins.
    always_comb begin
        grant = req_if | req_mem;
        owner = OWN_MEM;
        if (req_if && req_mem) begin
            owner = (last_owner == OWN_MEM) ? OWN_IF : OWN_MEM;
        end else if (req_if) begin
            owner = OWN_IF;
        end
    end
`else
    // Fixed priority: data accesses always beat fetches.
    always_comb begin
        grant = req_if | req_mem;
        owner = req_mem ? OWN_MEM : OWN_IF;
    end

    // History inputs only matter for round-robin.
    logic unused_pick;
    assign unused_pick = ^{clk, rst_n, done, done_owner};
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one bridge port between fetch (read-only) and LSU (read/write), one transaction at a time.
// Latency: bus_valid 1 cycle after grant; owner ready 1 cycle after bus_rvalid (3 cycles minimum).
// Backpressure: bus_valid held with stable payload until bus_ready; requesters hold valid until ready.
`include "config.sv"

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DW = `CPU_WIDTH
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          if_valid,
    input  logic [DW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    output logic [1:0]    if_resp,

    input  logic          mem_valid,
    input  logic          mem_write,
    input  logic [DW-1:0] mem_addr,
    input  logic [1:0]    mem_size,
    input  logic [DW-1:0] mem_wdata,
    input  logic [7:0]    mem_wmask,
    output logic          mem_ready,
    output logic [DW-1:0] mem_rdata,
    output logic [1:0]    mem_resp,

    output logic          bus_valid,
    input  logic          bus_ready,
    output logic          bus_write,
    output logic [DW-1:0] bus_addr,
    output logic [1:0]    bus_size,
    output logic [DW-1:0] bus_wdata,
    output logic [7:0]    bus_wmask,
    input  logic          bus_rvalid,
    input  logic [DW-1:0] bus_rdata,
    input  logic [1:0]    bus_resp
);

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;
    owner_t        pick_owner;
    logic          pick_grant;
    logic          take;
    logic          capture;

    logic          lat_write;
    logic [DW-1:0] lat_addr;
    logic [1:0]    lat_size;
    logic [DW-1:0] lat_wdata;
    logic [7:0]    lat_wmask;
    logic [DW-1:0] lat_rdata;
    logic [1:0]    lat_resp;

    mem_port_arbiter_arb_pick u_pick (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .req_if     (if_valid),
        .req_mem    (mem_valid),
        .done       (state == DONE),
        .done_owner (owner),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    assign take    = (state == IDLE) && pick_grant;
    // A response arriving together with the accept is taken immediately.
    assign capture = ((state == REQ) && bus_ready && bus_rvalid) ||
                     ((state == WAIT) && bus_rvalid);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; IDLE always lasts at least one cycle between transactions.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_grant) state_nxt = REQ;
            REQ:  if (bus_ready)  state_nxt = bus_rvalid ? DONE : WAIT;
            WAIT: if (bus_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winner's request at grant, and the bridge response when it arrives.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            owner     <= OWN_IF;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            lat_rdata <= '0;
            lat_resp  <= RESP_OKAY;
        end else begin
            if (take) begin
                owner <= pick_owner;
                if (pick_owner == OWN_MEM) begin
                    lat_write <= mem_write;
                    lat_addr  <= mem_addr;
                    lat_size  <= mem_size;
                    lat_wdata <= mem_wdata;
                    lat_wmask <= mem_wmask;
                end else begin
                    lat_write <= 1'b0;
                    lat_addr  <= if_addr;
                    lat_size  <= FETCH_SIZE;
                    lat_wdata <= '0;
                    lat_wmask <= '0;
                end
            end
            if (capture) begin
                lat_rdata <= bus_rdata;
                lat_resp  <= bus_resp;
            end
        end
    end

    assign bus_valid = (state == REQ);
    assign bus_write = lat_write;
    assign bus_addr  = lat_addr;
    assign bus_size  = lat_size;
    assign bus_wdata = lat_wdata;
    assign bus_wmask = lat_wmask;

    // Only the owner sees a completion; response fields are zero outside the pulse.
    assign if_ready  = (state == DONE) && (owner == OWN_IF);
    assign mem_ready = (state == DONE) && (owner == OWN_MEM);
    assign if_rdata  = if_ready  ? lat_rdata : '0;
    assign if_resp   = if_ready  ? lat_resp  : RESP_OKAY;
    assign mem_rdata = mem_ready ? lat_rdata : '0;
    assign mem_resp  = mem_ready ? lat_resp  : RESP_OKAY;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus hand-written multi-cycle sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
// Counts every comparison and prints one summary line.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        if_valid;
    logic [63:0] if_addr;
    logic        if_ready;
    logic [63:0] if_rdata;
    logic [1:0]  if_resp;
    logic        mem_valid;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [1:0]  mem_size;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic [1:0]  mem_resp;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic [63:0] bus_addr;
    logic [1:0]  bus_size;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic [1:0]  bus_resp;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DW(64)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .if_valid   (if_valid),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .if_resp    (if_resp),
        .mem_valid  (mem_valid),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_size   (mem_size),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_write  (bus_write),
        .bus_addr   (bus_addr),
        .bus_size   (bus_size),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata),
        .bus_resp   (bus_resp)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ifv;
        logic [63:0] ifa;
        logic        mv;
        logic        mw;
        logic [63:0] ma;
        logic [1:0]  msz;
        logic        br;
        logic        rv;
        logic [63:0] rd;
        logic [1:0]  rr;
        logic        e_bv;
        logic        e_bw;
        logic [63:0] e_ba;
        logic [1:0]  e_bs;
        logic        e_ir;
        logic        e_mr;
        logic [63:0] e_rd;
        logic [1:0]  e_resp;
    } vec_t;

    vec_t vq[$];

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, " bus_valid"}, 64'(bus_valid), 64'd0);
        chk({pfx, " if_ready"},  64'(if_ready),  64'd0);
        chk({pfx, " mem_ready"}, 64'(mem_ready), 64'd0);
        chk({pfx, " bus_write"}, 64'(bus_write), 64'd0);
        chk({pfx, " bus_addr"},  bus_addr,       64'd0);
        chk({pfx, " bus_size"},  64'(bus_size),  64'd0);
        chk({pfx, " bus_wdata"}, bus_wdata,      64'd0);
        chk({pfx, " bus_wmask"}, 64'(bus_wmask), 64'd0);
        chk({pfx, " if_rdata"},  if_rdata,       64'd0);
        chk({pfx, " if_resp"},   64'(if_resp),   64'd0);
        chk({pfx, " mem_rdata"}, mem_rdata,      64'd0);
        chk({pfx, " mem_resp"},  64'(mem_resp),  64'd0);
    endtask

    task automatic idle_inputs();
        if_valid   = 1'b0;
        if_addr    = '0;
        mem_valid  = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_size   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        bus_resp   = '0;
    endtask

    initial begin
        int       pulses;
        int       ng;
        int       if_left;
        int       mem_left;
        logic     order [4];
        logic     exp_order [4];

        // ---------------- reset ----------------
        idle_inputs();
        i_rst_n = 1'b0;
        step();
        step();
        chk_all_zero("reset");
        i_rst_n = 1'b1;
        step();

        // ---------------- per-cycle vector table ----------------
        // Each row: inputs for one cycle, then the outputs expected right after that edge.
        // fetch only, zero-wait bridge
        vq.push_back('{1, 64'h8000_0000, 0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0,
                       1, 0, 64'h8000_0000, `SIZE_W, 0, 0, 64'h0, 2'd0});
        vq.push_back('{1, 64'h8000_0000, 0, 0, 64'h0, 2'd0, 1, 1, 64'h13, 2'd0,
                       0, 0, 64'h0, 2'd0, 1, 0, 64'h13, 2'd0});
        vq.push_back('{1, 64'h8000_0000, 0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0,
                       0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0});
        vq.push_back('{0, 64'h0, 0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0,
                       0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0});
        // load with slave-error response
        vq.push_back('{0, 64'h0, 1, 0, 64'h1000, 2'd3, 0, 0, 64'h0, 2'd0,
                       1, 0, 64'h1000, 2'd3, 0, 0, 64'h0, 2'd0});
        vq.push_back('{0, 64'h0, 1, 0, 64'h1000, 2'd3, 1, 0, 64'h0, 2'd0,
                       0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0});
        vq.push_back('{0, 64'h0, 1, 0, 64'h1000, 2'd3, 0, 1, 64'hAAAA_5555_0000_1111, 2'b10,
                       0, 0, 64'h0, 2'd0, 0, 1, 64'hAAAA_5555_0000_1111, 2'b10});
        vq.push_back('{0, 64'h0, 1, 0, 64'h1000, 2'd3, 0, 0, 64'h0, 2'd0,
                       0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0});
        // next request after the error proceeds normally
        vq.push_back('{1, 64'h2000, 0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0,
                       1, 0, 64'h2000, `SIZE_W, 0, 0, 64'h0, 2'd0});
        vq.push_back('{1, 64'h2000, 0, 0, 64'h0, 2'd0, 1, 1, 64'h55, 2'd0,
                       0, 0, 64'h0, 2'd0, 1, 0, 64'h55, 2'd0});
        vq.push_back('{0, 64'h0, 0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0,
                       0, 0, 64'h0, 2'd0, 0, 0, 64'h0, 2'd0});

        for (int i = 0; i < vq.size(); i++) begin
            if_valid   = vq[i].ifv;
            if_addr    = vq[i].ifa;
            mem_valid  = vq[i].mv;
            mem_write  = vq[i].mw;
            mem_addr   = vq[i].ma;
            mem_size   = vq[i].msz;
            bus_ready  = vq[i].br;
            bus_rvalid = vq[i].rv;
            bus_rdata  = vq[i].rd;
            bus_resp   = vq[i].rr;
            step();
            chk($sformatf("vec%0d bus_valid", i), 64'(bus_valid), 64'(vq[i].e_bv));
            chk($sformatf("vec%0d if_ready", i),  64'(if_ready),  64'(vq[i].e_ir));
            chk($sformatf("vec%0d mem_ready", i), 64'(mem_ready), 64'(vq[i].e_mr));
            if (vq[i].e_bv) begin
                chk($sformatf("vec%0d bus_write", i), 64'(bus_write), 64'(vq[i].e_bw));
                chk($sformatf("vec%0d bus_addr", i),  bus_addr,       vq[i].e_ba);
                chk($sformatf("vec%0d bus_size", i),  64'(bus_size),  64'(vq[i].e_bs));
            end
            if (vq[i].e_ir) begin
                chk($sformatf("vec%0d if_rdata", i), if_rdata,      vq[i].e_rd);
                chk($sformatf("vec%0d if_resp", i),  64'(if_resp),  64'(vq[i].e_resp));
            end
            if (vq[i].e_mr) begin
                chk($sformatf("vec%0d mem_rdata", i), mem_rdata,     vq[i].e_rd);
                chk($sformatf("vec%0d mem_resp", i),  64'(mem_resp), 64'(vq[i].e_resp));
            end
        end
        idle_inputs();

        // ---------------- store, response 5 cycles after accept ----------------
        mem_write = 1'b1;
        mem_addr  = 64'h8000_1004;
        mem_size  = `SIZE_D;
        mem_wdata = 64'hDEADBEEF_0000_0000;
        mem_wmask = 8'hF0;
        pulses    = 0;
        for (int c = 0; c < 10; c++) begin
            mem_valid  = (c <= 7);
            bus_ready  = (c == 1);
            bus_rvalid = (c == 6);
            step();
            chk($sformatf("store c%0d bus_valid", c + 1), 64'(bus_valid), 64'(c + 1 == 1));
            chk($sformatf("store c%0d mem_ready", c + 1), 64'(mem_ready), 64'(c + 1 == 7));
            chk($sformatf("store c%0d if_ready", c + 1),  64'(if_ready),  64'd0);
            if (bus_valid) begin
                chk("store bus_write", 64'(bus_write), 64'd1);
                chk("store bus_addr",  bus_addr,       64'h8000_1004);
                chk("store bus_size",  64'(bus_size),  64'(`SIZE_D));
                chk("store bus_wdata", bus_wdata,      64'hDEADBEEF_0000_0000);
                chk("store bus_wmask", 64'(bus_wmask), 64'hF0);
            end
            if (mem_ready) pulses++;
        end
        chk("store ready pulse count", 64'(pulses), 64'd1);
        idle_inputs();

        // ---------------- bridge stalls 10 cycles, requester drops valid ----------------
        mem_write = 1'b1;
        mem_addr  = 64'h0000_4440;
        mem_size  = `SIZE_H;
        mem_wdata = 64'h0123_4567_89AB_CDEF;
        mem_wmask = 8'h0C;
        for (int c = 0; c < 15; c++) begin
            mem_valid = (c < 3);
            if (c >= 3) begin
                mem_write = 1'b0;
                mem_addr  = 64'hBAD0_BAD0;
                mem_size  = `SIZE_B;
                mem_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
                mem_wmask = 8'hFF;
            end
            bus_ready  = (c == 11);
            bus_rvalid = (c == 12);
            step();
            chk($sformatf("stall c%0d bus_valid", c + 1), 64'(bus_valid), 64'(c + 1 >= 1 && c + 1 <= 11));
            chk($sformatf("stall c%0d mem_ready", c + 1), 64'(mem_ready), 64'(c + 1 == 13));
            if (bus_valid) begin
                chk($sformatf("stall c%0d bus_write", c + 1), 64'(bus_write), 64'd1);
                chk($sformatf("stall c%0d bus_addr", c + 1),  bus_addr,       64'h0000_4440);
                chk($sformatf("stall c%0d bus_size", c + 1),  64'(bus_size),  64'(`SIZE_H));
                chk($sformatf("stall c%0d bus_wdata", c + 1), bus_wdata,      64'h0123_4567_89AB_CDEF);
                chk($sformatf("stall c%0d bus_wmask", c + 1), 64'(bus_wmask), 64'h0C);
            end
        end
        idle_inputs();

        // ---------------- contention: each side wants two loads ----------------
        i_rst_n = 1'b0;
        step();
        i_rst_n = 1'b1;
        if_left    = 2;
        mem_left   = 2;
        ng         = 0;
        if_valid   = 1'b1;
        if_addr    = 64'h100;
        mem_valid  = 1'b1;
        mem_addr   = 64'h200;
        mem_size   = `SIZE_D;
        bus_ready  = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'h77;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            step();
            if (if_ready) begin
                order[ng] = 1'b0;
                ng++;
                if_left--;
                if (if_left == 0) if_valid = 1'b0;
            end else if (mem_ready) begin
                order[ng] = 1'b1;
                ng++;
                mem_left--;
                if (mem_left == 0) mem_valid = 1'b0;
            end
        end
`ifdef ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
        chk("contend grant count", 64'(ng), 64'd4);
        for (int g = 0; g < ng; g++) begin
            chk($sformatf("contend grant%0d owner(1=mem)", g), 64'(order[g]), 64'(exp_order[g]));
        end
        idle_inputs();
        step();

        // ---------------- reset while waiting for the response ----------------
        mem_valid = 1'b1;
        mem_addr  = 64'h3000;
        step();
        chk("rstwait bus_valid in REQ", 64'(bus_valid), 64'd1);
        bus_ready = 1'b1;
        step();
        bus_ready = 1'b0;
        step();
        chk("rstwait bus_valid in WAIT", 64'(bus_valid), 64'd0);
        i_rst_n   = 1'b0;
        mem_valid = 1'b0;
        step();
        chk_all_zero("rstwait");
        i_rst_n    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 64'hDEAD;
        step();
        chk("late rvalid mem_ready", 64'(mem_ready), 64'd0);
        chk("late rvalid if_ready",  64'(if_ready),  64'd0);
        bus_rvalid = 1'b0;
        step();
        chk("late rvalid+1 mem_ready", 64'(mem_ready), 64'd0);
        chk("late rvalid+1 bus_valid", 64'(bus_valid), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory bus port between the instruction fetch unit (read-only) and the load/store unit (read/write). It sits between those two requesters and the AXI bridge. It accepts one transaction at a time, latches the winner's payload, and drives the bridge. It then returns the bridge response to the winning requester only. It replaces the direct LSU-to-bridge connection so that fetch and data accesses never collide on the bus.

## Interface
Parameters:
- DW, default `CPU_WIDTH` (64): address and data width.

Ports:
- i_clk, in, 1: core clock. Single clock domain.
- i_rst_n, in, 1: synchronous, active-low reset.
- if_valid, in, 1: fetch request. Held high until if_ready.
- if_addr, in, DW: fetch address.
- if_ready, out, 1: one-cycle completion pulse to fetch.
- if_rdata, out, DW: fetch read data. Valid only while if_ready is high.
- if_resp, out, 2: fetch response code.
- mem_valid, in, 1: LSU request. Held high until mem_ready.
- mem_write, in, 1: 1 = store, 0 = load.
- mem_addr, in, DW: LSU address.
- mem_size, in, 2: LSU access size.
- mem_wdata, in, DW: LSU store data.
- mem_wmask, in, 8: LSU byte strobes.
- mem_ready, out, 1: one-cycle completion pulse to the LSU.
- mem_rdata, out, DW: LSU read data. Valid only while mem_ready is high.
- mem_resp, out, 2: LSU response code.
- bus_valid, out, 1: request to the bridge.
- bus_ready, in, 1: bridge accepted the request.
- bus_write, out, 1: request type, 1 = write.
- bus_addr, out, DW: request address.
- bus_size, out, 2: request size.
- bus_wdata, out, DW: request write data.
- bus_wmask, out, 8: request byte strobes.
- bus_rvalid, in, 1: bridge response is valid. Covers both read data and write completion.
- bus_rdata, in, DW: bridge read data.
- bus_resp, in, 2: bridge response code.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- IDLE: if if_valid or mem_valid is high, pick a winner. Latch the winner's owner ID, address, size, write, wdata and wmask. Go to REQ.
- Latched values for a fetch: bus_write=0, bus_size=`SIZE_W`, bus_wmask=0, bus_wdata=0.
- REQ: drive bus_valid=1 with the latched payload. When bus_ready=1, go to WAIT.
- WAIT: when bus_rvalid=1, latch bus_rdata and bus_resp. Go to DONE.
- A bus_rvalid that arrives in the same cycle as bus_ready in REQ is also captured. In that case the FSM goes directly to DONE.
- DONE: pulse the owner's ready for one cycle with the latched rdata/resp, then return to IDLE.
- The non-owner's ready stays 0 for the whole transaction.
- Arbitration with the macro undefined: fixed priority, mem over if.
- A requester that is not selected in IDLE keeps its valid high and is served in a later IDLE cycle.
- Response codes are forwarded unmodified. A non-zero resp still completes normally; the arbiter does not retry.
- A requester deasserting valid mid-transaction has no effect; the latched payload is used.
- bus_rvalid outside WAIT/REQ is ignored.

## Timing
- Reset values (all outputs): bus_valid=0, if_ready=0, mem_ready=0. All data, addr, resp, mask, size and write outputs are 0.
- Reset mid-transaction: the FSM returns to IDLE and the transaction is dropped. The bridge is reset by the same i_rst_n.
- Latency from requester valid (IDLE, cycle 0) to bus_valid: cycle 1.
- With bus_ready in cycle k and bus_rvalid in cycle m>k, the owner's ready pulse is in cycle m+1.
- Zero-wait bridge (bus_ready and bus_rvalid both in cycle 1): ready pulses in cycle 2, so the minimum is 3 cycles per transaction.
- Back-to-back transactions: IDLE is always visited for 1 cycle between transactions, so the next bus_valid appears no earlier than 2 cycles after the previous ready pulse.
- bus_* payload is stable for every cycle that bus_valid=1.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit last_owner register resets to "mem".
  - When both requesters are valid in IDLE, the requester that is not last_owner wins.
  - last_owner updates on every DONE.
  - A single requester always wins immediately.
- ARB_RR_EN undefined: fixed priority, mem over if. No last_owner register.

## Structure
- The shared package holds:
  - the state enum (IDLE, REQ, WAIT, DONE);
  - the owner enum (OWN_IF, OWN_MEM);
  - the response code constants.
- `SIZE_*` and `CPU_WIDTH` remain in config.sv.
- One sub-module, arb_pick: combinational selection of two requesters. Under ARB_RR_EN it also holds the last_owner register.

## Test plan
- Fetch only, if_addr=0x8000_0000, bridge answers bus_ready in cycle 1 and bus_rvalid in cycle 1 with bus_rdata=0x0000_0013 -> bus_size=`SIZE_W`, bus_write=0, if_ready=1 in cycle 2, if_rdata=0x13, mem_ready never asserted.
- Store only, mem_addr=0x8000_1004, mem_wmask=0xF0, mem_wdata=0xDEADBEEF_00000000, 5-cycle rvalid delay -> bus payload matches for every bus_valid cycle, mem_ready pulses exactly once, the cycle after bus_rvalid.
- Both valid in the same IDLE cycle, macro undefined -> mem served first, then if. With ARB_RR_EN, two consecutive contended rounds -> grants are if then mem.
- bus_rvalid with bus_resp=2'b10 on a load -> mem_resp=2'b10 with the ready pulse. The FSM returns to IDLE and the next request proceeds normally.
- Assert i_rst_n=0 while in WAIT -> the next cycle shows the FSM in IDLE and all outputs 0. A late bus_rvalid after reset produces no ready pulse.
- bus_ready held 0 for 10 cycles -> bus_valid and payload stay constant throughout. Requester deasserting valid during this time does not alter the payload.
